slr_credit_tx: RTL

//  Transmit end of a credit-based inter-SLR link. Accepts words from a local valid/ready producer and

---
 rtl/slr_credit_tx_if.sv | 30 +++
 rtl/slr_credit_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/slr_credit_tx_if.sv
// Producer-side and link-side handshake bundle for slr_credit_tx.
// master: the producer / remote-receiver side; slave: the credit transmitter.
interface slr_credit_tx_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bits;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_bits;
    logic             credit_in;

    modport master (
        output in_valid,
        output in_bits,
        output credit_in,
        input  in_ready,
        input  tx_valid,
        input  tx_bits
    );

    modport slave (
        input  in_valid,
        input  in_bits,
        input  credit_in,
        output in_ready,
        output tx_valid,
        output tx_bits
    );
endinterface

// File: rtl/slr_credit_tx.sv
// Credit-based transmit end of an inter-SLR link.
// Holds one token per free slot in the remote receive FIFO, spends one per word sent and recovers
// one per (registered) credit_in pulse. All link-facing outputs are registered.
// Optional statistics counters are enabled by defining SLR_CREDIT_TX_STATS_EN.
module slr_credit_tx #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CREDITS  = 8,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    slr_credit_tx_if.slave      link,
    output logic [CREDIT_W-1:0] credit_count,
    output logic [1:0]          link_state,
`ifdef SLR_CREDIT_TX_STATS_EN
    output logic [31:0]         tx_word_count,
    output logic [31:0]         stall_cycles,
`endif
    output logic                credit_err
);

    localparam logic [CREDIT_W-1:0] Full = CREDIT_W'(CREDITS);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StStall = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                credit_q;
    logic                tx_valid_q;
    logic [WIDTH-1:0]    tx_bits_q;
    logic                credit_err_q;
    logic                in_ready;
    logic                send;
    logic                overflow;

    // Ready depends only on the token register so no combinational path runs from in_valid.
    assign in_ready = (credits_q != '0);
    assign send     = link.in_valid & in_ready;

    // Token count next-state; a return with nothing spent at full count is an overflow and saturates.
    always_comb begin
        credits_d = credits_q;
        overflow  = 1'b0;
        if (send && !credit_q) begin
            credits_d = credits_q - 1'b1;
        end else if (!send && credit_q) begin
            if (credits_q == Full) begin
                overflow = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    // Link state follows where the token count is heading.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (credits_d == '0)        state_d = StStall;
                else if (credits_d != Full) state_d = StBusy;
            end
            StBusy: begin
                if (credits_d == '0)        state_d = StStall;
                else if (credits_d == Full) state_d = StIdle;
            end
            StStall: begin
                if (credits_d == Full)      state_d = StIdle;
                else if (credits_d != '0)   state_d = StBusy;
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit capture, token counter, FSM, registered link outputs and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_q     <= 1'b0;
            credits_q    <= Full;
            state_q      <= StIdle;
            tx_valid_q   <= 1'b0;
            tx_bits_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q   <= link.credit_in;
            credits_q  <= credits_d;
            state_q    <= state_d;
            tx_valid_q <= send;
            if (send) begin
                tx_bits_q <= link.in_bits;
            end
            if (overflow) begin
                credit_err_q <= 1'b1;
            end
        end
    end

`ifdef SLR_CREDIT_TX_STATS_EN
    logic [31:0] tx_word_count_q;
    logic [31:0] stall_cycles_q;

    // Word counter wraps; stall counter saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_word_count_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            if (send) begin
                tx_word_count_q <= tx_word_count_q + 32'd1;
            end
            if (link.in_valid && !in_ready && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign tx_word_count = tx_word_count_q;
    assign stall_cycles  = stall_cycles_q;
`endif

    assign link.in_ready = in_ready;
    assign link.tx_valid = tx_valid_q;
    assign link.tx_bits  = tx_bits_q;
    assign credit_count  = credits_q;
    assign link_state    = state_q;
    assign credit_err    = credit_err_q;

endmodule
